// File: rtl/mdu_divider_iter.sv
// rtl/mdu_divider_iter.sv - iterative radix-2^K restoring divider with tag, flush and degenerate-operand fast path
// Optional: define MDU_DIV_EARLY_OUT_EN to finish |Z| < |D| requests at accept.
module mdu_divider_iter #(
  parameter int WIDTH = 32,
  parameter int K     = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_signed_i,
  input  logic [WIDTH-1:0] req_z_i,
  input  logic [WIDTH-1:0] req_d_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_q_o,
  output logic [WIDTH-1:0] resp_r_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o
);

  localparam int ITERS = WIDTH / K;
  localparam int CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               q_neg_q;
  logic               r_neg_q;

  logic               z_neg, d_neg;
  logic [WIDTH-1:0]   abs_z, abs_d;
  logic               d_zero, ovf, early, special;
  logic [WIDTH:0]     rem_n, diff_v;
  logic [WIDTH-1:0]   quo_n;

  assign z_neg  = req_signed_i & req_z_i[WIDTH-1];
  assign d_neg  = req_signed_i & req_d_i[WIDTH-1];
  assign abs_z  = z_neg ? (~req_z_i + 1'b1) : req_z_i;
  assign abs_d  = d_neg ? (~req_d_i + 1'b1) : req_d_i;
  assign d_zero = (req_d_i == '0);
  assign ovf    = req_signed_i && (req_z_i == {1'b1, {(WIDTH-1){1'b0}}}) && (req_d_i == '1);
`ifdef MDU_DIV_EARLY_OUT_EN
  assign early  = !d_zero && (abs_z < abs_d);
`else
  assign early  = 1'b0;
`endif
  assign special = d_zero | ovf | early;

  // K chained restoring steps; partial remainder is one bit wider than the divisor
  always_comb begin
    rem_n  = rem_q;
    quo_n  = quo_q;
    diff_v = '0;
    for (int i = 0; i < K; i++) begin
      rem_n  = {rem_n[WIDTH-1:0], quo_n[WIDTH-1]};
      diff_v = rem_n - {1'b0, dvs_q};
      if (!diff_v[WIDTH]) begin
        rem_n = diff_v;
        quo_n = {quo_n[WIDTH-2:0], 1'b1};
      end else begin
        quo_n = {quo_n[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      resp_q_o   <= '0;
      resp_r_o   <= '0;
      resp_tag_o <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          rem_q      <= '0;
          quo_q      <= abs_z;
          dvs_q      <= abs_d;
          q_neg_q    <= z_neg ^ d_neg;
          r_neg_q    <= z_neg;
          resp_tag_o <= req_tag_i;
          cnt_q      <= special ? '0 : CNT_W'(ITERS);
          if (d_zero) begin
            resp_q_o <= '1;
            resp_r_o <= req_z_i;
          end else if (ovf) begin
            resp_q_o <= req_z_i;
            resp_r_o <= '0;
          end else if (early) begin
            resp_q_o <= '0;
            resp_r_o <= req_z_i;
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            resp_q_o <= q_neg_q ? (~quo_n + 1'b1) : quo_n;
            resp_r_o <= r_neg_q ? (~rem_n[WIDTH-1:0] + 1'b1) : rem_n[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mdu_divider_iter.sv
// tb/tb_mdu_divider_iter.sv - directed-vector bench for mdu_divider_iter (WIDTH=32, K=2)
module tb_mdu_divider_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_z_i = '0;
  logic [31:0] req_d_i = '0;
  logic [3:0]  req_tag_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_q_o;
  logic [31:0] resp_r_o;
  logic [3:0]  resp_tag_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 17;
`endif

  mdu_divider_iter #(.WIDTH(32), .K(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_signed_i(req_signed_i),
    .req_z_i(req_z_i), .req_d_i(req_d_i), .req_tag_i(req_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_q_o(resp_q_o), .resp_r_o(resp_r_o), .resp_tag_o(resp_tag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept edge ends cycle 0; lat counts the cycle in which resp_valid_o is first seen.
  task automatic do_div(input string name, input logic sgn, input logic [31:0] z,
                        input logic [31:0] d, input logic [3:0] tag,
                        input logic [31:0] eq, input logic [31:0] er, input int elat);
    int lat;
    @(negedge clk);
    req_valid_i = 1'b1; req_signed_i = sgn; req_z_i = z; req_d_i = d; req_tag_i = tag;
    check({name, " ready"}, req_ready_o, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " lat"}, lat, elat);
    check({name, " q"}, resp_q_o, eq);
    check({name, " r"}, resp_r_o, er);
    check({name, " tag"}, resp_tag_o, tag);
    if (resp_ready_i) begin
      @(posedge clk); #1;
      check({name, " idle"}, {resp_valid_o, req_ready_o, busy_o}, 3'b010);
    end
  endtask

  initial begin
    logic [31:0] hq, hr;
    repeat (3) @(posedge clk);
    #1;
    check("rst", {req_ready_o, resp_valid_o, busy_o}, 3'b100);
    check("rst out", {resp_q_o, resp_r_o, resp_tag_o}, 68'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_div("u100_7",  1'b0, 32'd100,      32'd7,        4'd3,  32'd14,       32'd2,        17);
    do_div("s-7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        4'd4,  32'hFFFFFFFD, 32'hFFFFFFFF, 17);
    do_div("s7_-2",   1'b1, 32'd7,        32'hFFFFFFFE, 4'd5,  32'hFFFFFFFD, 32'd1,        17);
    do_div("s-7_-2",  1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 4'd6,  32'd3,        32'hFFFFFFFF, 17);
    do_div("div0",    1'b0, 32'h1234,     32'd0,        4'd7,  32'hFFFFFFFF, 32'h1234,     1);
    do_div("ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 4'd8,  32'h80000000, 32'd0,        1);
    do_div("umax_1",  1'b0, 32'hFFFFFFFF, 32'd1,        4'd9,  32'hFFFFFFFF, 32'd0,        17);
    do_div("u3_10",   1'b0, 32'd3,        32'd10,       4'd10, 32'd0,        32'd3,        EARLY_LAT);
    do_div("u8m_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 4'd11, 32'd0,        32'h80000000, EARLY_LAT);

    // flush in CALC cycle 5, then immediate new request
    @(negedge clk);
    req_valid_i = 1'b1; req_signed_i = 1'b0; req_z_i = 32'd1000; req_d_i = 32'd7; req_tag_i = 4'd1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("flush pre busy", busy_o, 1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush post", {busy_o, req_ready_o, resp_valid_o}, 3'b010);
    do_div("after_flush", 1'b0, 32'd9, 32'd3, 4'd2, 32'd3, 32'd0, 17);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    req_valid_i = 1'b1; flush_i = 1'b1; req_z_i = 32'd5; req_d_i = 32'd0;
    @(posedge clk); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    check("flush idle", {busy_o, req_ready_o}, 2'b01);

    // consumer stalls for 10 cycles in DONE
    resp_ready_i = 1'b0;
    do_div("hold", 1'b0, 32'd100, 32'd7, 4'd12, 32'd14, 32'd2, 17);
    hq = resp_q_o; hr = resp_r_o;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold st", {resp_valid_o, req_ready_o, busy_o, resp_tag_o, resp_q_o, resp_r_o},
            {3'b101, 4'd12, 32'd14, 32'd2});
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    check("hold rel", {resp_valid_o, req_ready_o}, 2'b01);

    // reset mid-operation
    @(negedge clk);
    req_valid_i = 1'b1; req_z_i = 32'd50; req_d_i = 32'd3;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst mid", {busy_o, req_ready_o, resp_valid_o, resp_q_o}, {3'b010, 32'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_div("post_rst", 1'b0, 32'd50, 32'd3, 4'd13, 32'd16, 32'd2, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_divider_iter.md
# mdu_divider_iter

Parametrised iterative integer divider and successor to the fixed 32-bit radix-2 divider used by the MDU. It is generalised in operand width and bits retired per cycle, and gains a result tag, synchronous flush, and a single-cycle fast path for degenerate operands. It sits behind the MDU's final stage. Requests are issued over a valid/ready handshake, and results are returned over a second valid/ready handshake that the pipeline stall logic consumes.

## Interface
- `WIDTH`, 32: operand/result width. Must be ≥ 4 and even.
- `K`, 2: quotient bits retired per CALC cycle. Must be 1, 2 or 4, and WIDTH % K == 0.
- `TAG_W`, 4: width of the opaque tag carried from request to response.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous abort; drops any in-flight operation.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  divider can accept a request.
- `req_signed_i`  in  1  1 = two's-complement operands, 0 = unsigned.
- `req_z_i`  in  WIDTH  dividend.
- `req_d_i`  in  WIDTH  divisor.
- `req_tag_i`  in  TAG_W  tag.
- `resp_valid_o`  out  1  result present.
- `resp_ready_i`  in  1  consumer takes the result.
- `resp_q_o`  out  WIDTH  quotient.
- `resp_r_o`  out  WIDTH  remainder.
- `resp_tag_o`  out  TAG_W  tag of the result.
- `busy_o`  out  1  1 in CALC or DONE.

## Operation
- FSM states are IDLE, CALC and DONE.
  - `req_ready_o` = (state == IDLE).
  - `resp_valid_o` = (state == DONE).
- IDLE: on `req_valid_i & req_ready_o`, register the following:
  - magnitudes |Z| and |D| (equal to raw values when unsigned);
  - sign of the quotient, Z_neg XOR D_neg;
  - sign of the remainder, Z_neg;
  - the tag.
- IDLE next state:
  - DONE if the request is a special case;
  - otherwise CALC, with iteration counter = WIDTH/K.
- Special cases, all going straight to DONE:
  - D == 0: q = all ones, r = Z.
  - Signed, Z == most-negative, D == −1: q = Z, r = 0.
- CALC: each cycle performs K chained restoring shift-subtract steps on the partial remainder (WIDTH+1 bits) and the quotient shift register, then decrements the counter.
  - On the cycle where the counter goes from 1 to 0, apply sign correction and register the final q/r, then go to DONE.
  - Signed semantics: quotient truncates toward zero; remainder takes the dividend's sign, so q·D + r == Z.
- DONE: hold `resp_q_o`, `resp_r_o` and `resp_tag_o` stable until `resp_ready_i`, then go to IDLE.
  - No new request is accepted in the same cycle (ready is low in DONE).
- `flush_i`:
  - takes priority over every transition, including a request accept or response handshake in the same cycle;
  - next state is IDLE;
  - the result is discarded and the counter cleared;
  - in IDLE it blocks acceptance that cycle.
- Reset values: state IDLE, `req_ready_o` = 1, `resp_valid_o` = 0, `busy_o` = 0, `resp_q_o`/`resp_r_o`/`resp_tag_o` = 0.
- Reset mid-operation aborts with no response.

## Timing
- Count the accept cycle as cycle 0.
  - Normal path: CALC occupies cycles 1 … WIDTH/K, and `resp_valid_o` rises in cycle WIDTH/K + 1.
  - Defaults (32/2): result in cycle 17.
- Special cases: `resp_valid_o` in cycle 1.
- Back-to-back: the earliest next accept is the cycle after the response handshake. Throughput is one division per WIDTH/K + 2 cycles when the consumer is always ready.
- Outputs are registered. There is no combinational path from `req_*` to `resp_*`.

## Configuration
- `MDU_DIV_EARLY_OUT_EN`:
  - Defined: an additional fast path at accept. If |Z| < |D| (unsigned magnitude compare, D ≠ 0), go straight to DONE with q = 0 and r = Z, giving a result in cycle 1.
  - Undefined: such requests take the full WIDTH/K CALC cycles and produce the same values.

## Test plan
- Unsigned 100 / 7, tag 3 (WIDTH=32, K=2) → `resp_valid_o` in cycle 17, q = 14, r = 2, tag = 3.
- Signed −7 / 2 → q = −3 (0xFFFFFFFD), r = −1. Signed 7 / −2 → q = −3, r = 1.
- Divisor 0 with Z = 0x1234 → cycle 1, q = 0xFFFFFFFF, r = 0x1234. Signed 0x80000000 / −1 → cycle 1, q = 0x80000000, r = 0.
- `flush_i` pulsed in CALC cycle 5:
  - `busy_o` = 0 and `req_ready_o` = 1 the next cycle, with no response;
  - an immediate new request 9 / 3 then returns q = 3, r = 0.
- `resp_ready_i` held low for 10 cycles in DONE → `resp_valid_o` and outputs stable, `req_ready_o` = 0 throughout.
- Unsigned 3 / 10 → q = 0, r = 3. Result in cycle 1 with `MDU_DIV_EARLY_OUT_EN`, cycle 17 without.
